mac_acc_seq: RTL and testbench



---
 rtl/mac_acc_seq.sv | 156 +++++++++++++++
 tb/tb_mac_acc_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_seq.sv
`default_nettype none
// ============================================================================
// Module      : mac_acc_seq
// Description : Sequencer/accumulator around a multi-cycle signed 32x32
//               multiplier. Issues one operand pair at a time, sums the
//               64-bit products of a dot product (closed by in_last) and
//               emits an arithmetically shifted, int32-saturated result.
//               Optional macro MAC_RELU_EN clamps negative results to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_acc_seq #(
    parameter int SHIFT  = 0,
    parameter int TERM_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic              in_last,
    output logic              mul_valid,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic              mul_ready,
    input  logic [63:0]       mul_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [TERM_W-1:0] out_terms
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [TERM_W-1:0] c_TERM_ONE = TERM_W'(1);
    localparam logic [TERM_W-1:0] c_TERM_MAX = '1;
    localparam logic [31:0]       c_SAT_POS  = 32'h7FFF_FFFF;
    localparam logic [31:0]       c_SAT_NEG  = 32'h8000_0000;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_last;
    logic signed [63:0] r_acc;
    logic [TERM_W-1:0]  r_terms;

    logic               w_capture;
    logic               w_absorb;
    logic               w_accept;
    logic signed [63:0] w_shifted;
    logic               w_fits;
    logic [31:0]        w_sat;
    logic [31:0]        w_result;

    // The multiplier samples its operands while idle, so they come only from
    // the capture registers and stay put until the next capture.
    assign mul_a = r_a;
    assign mul_b = r_b;

    assign w_capture = in_valid  && (r_state == S_IDLE);
    assign w_absorb  = mul_ready && (r_state == S_WAIT);
    assign w_accept  = out_ready && (r_state == S_OUT);

    // Shift then saturate: the value fits in int32 when bits 63..31 agree.
    assign w_shifted = r_acc >>> SHIFT;
    assign w_fits    = (&w_shifted[63:31]) | ~(|w_shifted[63:31]);
    assign w_sat     = w_fits ? w_shifted[31:0]
                              : (w_shifted[63] ? c_SAT_NEG : c_SAT_POS);

`ifdef MAC_RELU_EN
    assign w_result = w_sat[31] ? 32'h0000_0000 : w_sat;
`else
    assign w_result = w_sat;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, product accumulation and term counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_last  <= 1'b0;
            r_acc   <= '0;
            r_terms <= '0;
        end else begin
            if (w_capture) begin
                r_a    <= in_a;
                r_b    <= in_b;
                r_last <= in_last;
            end
            if (w_absorb) begin
                r_acc <= r_acc + $signed(mul_result);
                if (r_terms != c_TERM_MAX) begin
                    r_terms <= r_terms + c_TERM_ONE;
                end
            end else if (w_accept) begin
                r_acc   <= '0;
                r_terms <= '0;
            end
        end
    end

    // Next-state and handshake outputs; result outputs read zero outside OUT.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        mul_valid   = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_terms   = '0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_valid   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mul_ready) begin
                    w_state_nxt = r_last ? S_OUT : S_IDLE;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = w_result;
                out_terms = r_terms;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_acc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_acc_seq
// Description : Directed self-checking bench for mac_acc_seq. Two instances
//               (SHIFT=0 and SHIFT=4) share stimulus and a behavioural
//               multiplier with fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_acc_seq;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_last;
    logic        out_ready;

    wire         in_ready,  in_ready4;
    wire         mul_valid, mul_valid4;
    wire  [31:0] mul_a, mul_b, mul_a4, mul_b4;
    wire         out_valid, out_valid4;
    wire  [31:0] out_data,  out_data4;
    wire  [15:0] out_terms, out_terms4;
    wire         mul_ready;
    wire  [63:0] mul_result;

    logic        pulse = 1'b0;
    logic        spur  = 1'b0;
    logic        busy  = 1'b0;
    int          cnt   = 0;
    logic [63:0] prod  = '0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    assign mul_ready  = pulse | spur;
    assign mul_result = spur ? 64'h0000_0000_0000_1234 : prod;

    always #5 clk = ~clk;

    mac_acc_seq #(.SHIFT(0), .TERM_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_terms(out_terms)
    );

    mac_acc_seq #(.SHIFT(4), .TERM_W(16)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_valid(mul_valid4), .mul_a(mul_a4), .mul_b(mul_b4),
        .mul_ready(mul_ready), .mul_result(mul_result),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_terms(out_terms4)
    );

    // Behavioural multiplier: product pulse LAT negedges after the start pulse.
    always @(negedge clk) begin
        if (rst) begin
            busy  = 1'b0;
            pulse = 1'b0;
        end else begin
            if (pulse) pulse = 1'b0;
            if (busy) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    pulse = 1'b1;
                    busy  = 1'b0;
                end
            end
            if (mul_valid) begin
                busy = 1'b1;
                cnt  = LAT;
                prod = 64'($signed(mul_a) * $signed(mul_b));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef MAC_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'hCAFE_F00D;
        in_last  = 1'b0;
        chk("mul_valid_pulse", mul_valid, 1);
        chk("in_ready_busy", in_ready, 0);
        chk("mul_a_issue", mul_a, a);
        chk("mul_b_issue", mul_b, b);
        @(negedge clk);
        chk("mul_valid_drop", mul_valid, 0);
        last_a = a;
        last_b = b;
    endtask

    task automatic get_out(input logic [31:0] e0, input logic [31:0] e4,
                           input logic [15:0] et, input int hold);
        int n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid", out_valid, 1);
        chk("out_valid_s4", out_valid4, 1);
        chk("out_data", out_data, e0);
        chk("out_data_s4", out_data4, e4);
        chk("out_terms", out_terms, et);
        chk("out_terms_s4", out_terms4, et);
        chk("mul_a_hold", mul_a, last_a);
        chk("mul_b_hold", mul_b, last_b);
        chk("in_ready_out", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, e0);
            chk("bp_terms", out_terms, et);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("out_data_idle", out_data, 0);
        chk("out_terms_idle", out_terms, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    // Directed sequence.
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mul_valid", mul_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_terms", out_terms, 0);
        rst = 1'b0;
        @(negedge clk);

        // Two-term dot product: 12 - 10 = 2.
        send(32'd3, 32'd4, 1'b0);
        send(-32'sd2, 32'd5, 1'b1);
        get_out(32'h0000_0002, 32'h0000_0000, 16'd2, 0);

        // Positive and negative saturation; SHIFT=4 brings them in range.
        send(32'd65536, 32'd65536, 1'b1);
        get_out(32'h7FFF_FFFF, 32'h1000_0000, 16'd1, 0);
        send(-32'sd65536, 32'd65536, 1'b1);
        get_out(relu(32'h8000_0000), relu(32'hF000_0000), 16'd1, 0);

        // Arithmetic shift rounds toward minus infinity.
        send(-32'sd7, 32'd1, 1'b1);
        get_out(relu(32'hFFFF_FFF9), relu(32'hFFFF_FFFF), 16'd1, 0);
        send(32'd160, 32'd1, 1'b1);
        get_out(32'h0000_00A0, 32'h0000_000A, 16'd1, 0);

        // Backpressure for 10 cycles on a negative result.
        send(-32'sd3, 32'd4, 1'b1);
        get_out(relu(32'hFFFF_FFF4), relu(32'hFFFF_FFFF), 16'd1, 10);

        // Spurious product pulse while idle must not reach the accumulator.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        send(32'd1, 32'd1, 1'b1);
        get_out(32'h0000_0001, 32'h0000_0000, 16'd1, 0);

        // Reset while waiting on the multiplier discards the partial sum.
        send(32'd5, 32'd5, 1'b0);
        send(32'd6, 32'd6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_mul_valid", mul_valid, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_mul_a", mul_a, 0);
        chk("mid_rst_mul_b", mul_b, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_terms", out_terms, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        last_a = '0;
        last_b = '0;
        send(32'd2, 32'd3, 1'b1);
        get_out(32'h0000_0006, 32'h0000_0000, 16'd1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
